// File: rtl/save_path_packer_pkg.sv
// ---------------------------------------------------------------------------
// save_path_packer_pkg
// Shared definitions for the save-path packer: sequencer state encoding,
// the default path length and the fixed pieces of the save-file path
// "/Saves/camera/common/SRAM_" + two decimal digits + ".sav".
// ---------------------------------------------------------------------------
package save_path_packer_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_PAD    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Full path is prefix (26) + two index digits (2) + suffix (4) = 32 bytes
  localparam int DEFAULT_PATH_LENGTH = 32;
  localparam int PATH_PREFIX_LEN     = 26;
  localparam int PATH_SUFFIX_LEN     = 4;

  // Number of 32-bit words needed for a path plus its zero terminator
  function automatic int words_for_length(input int len);
    return (len + 4) / 4;
  endfunction

endpackage

// File: rtl/save_path_packer_byte_word_packer.sv
// ---------------------------------------------------------------------------
// byte_word_packer
// Collects a byte stream into big-endian 32-bit words. The first byte of a
// word lands in [31:24]. A word is emitted (word_valid pulses for one cycle,
// word holds the value until the next word) after the fourth byte, or early
// when a byte arrives with flush set; in that case the unused low bytes of
// the word are zero.
//
// Ports
//   clk, reset_n : clock, asynchronous active-low reset
//   byte_valid   : byte_in carries a byte this cycle
//   byte_in      : byte to append
//   flush        : this byte closes the current word (zero fill below it)
//   word_valid   : one-cycle pulse, word is new
//   word         : last completed word (0 after reset)
// ---------------------------------------------------------------------------
module byte_word_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        flush,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] word_q, word_d;
  logic [31:0] aligned_s;

  // Left-align the bytes collected so far plus the incoming byte
  always_comb begin
    aligned_s = 32'h0000_0000;
    case (cnt_q)
      2'd0:    aligned_s = {byte_in, 24'h00_0000};
      2'd1:    aligned_s = {acc_q[7:0], byte_in, 16'h0000};
      2'd2:    aligned_s = {acc_q[15:0], byte_in, 8'h00};
      2'd3:    aligned_s = {acc_q, byte_in};
      default: aligned_s = 32'h0000_0000;
    endcase
  end

  // Shift in bytes and emit a word on the fourth byte or on flush
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    if (byte_valid) begin
      if (flush || (cnt_q == 2'd3)) begin
        word_valid_d = 1'b1;
        word_d       = aligned_s;
        acc_d        = 24'h00_0000;
        cnt_d        = 2'd0;
      end else begin
        acc_d = {acc_q[15:0], byte_in};
        cnt_d = cnt_q + 2'd1;
      end
    end else begin
      word_valid_d = 1'b0;
    end
  end

  // Packer state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= 24'h00_0000;
      cnt_q        <= 2'd0;
      word_valid_q <= 1'b0;
      word_q       <= 32'h0000_0000;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule

// File: rtl/save_path_packer.sv
// ---------------------------------------------------------------------------
// save_path_packer
// On start, reads PATH_LENGTH bytes of the save-file path for the requested
// slot from an external path source (1-cycle read latency), appends a zero
// terminator, zero-fills to a word boundary and writes the result as
// big-endian 32-bit words into a bridge buffer starting at BASE_WORD_ADDR
// (6-bit address, wraps modulo 64). done pulses the cycle after the final
// word write.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   start          : one-cycle request, ignored while busy
//   save_index_in  : requested slot (0..99)
//   save_index     : slot latched at start, held for the path source
//   path_address   : byte address to the path source
//   path_q         : path byte, valid one cycle after path_address
//   word_wr        : bridge buffer write strobe
//   word_addr      : bridge buffer word address
//   word_data      : packed path word
//   busy           : sequence in progress
//   done           : one-cycle completion pulse
// ---------------------------------------------------------------------------
module save_path_packer
  import save_path_packer_pkg::*;
#(
  parameter int PATH_LENGTH    = DEFAULT_PATH_LENGTH,
  parameter int BASE_WORD_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [6:0]  save_index_in,
  output logic [6:0]  save_index,
  output logic [7:0]  path_address,
  input  logic [7:0]  path_q,
  output logic        word_wr,
  output logic [5:0]  word_addr,
  output logic [31:0] word_data,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] LAST_ADDR = 8'(PATH_LENGTH - 1);
  localparam logic [5:0] BASE_ADDR = 6'(BASE_WORD_ADDR % 64);

  state_e      state_q, state_d;
  logic [6:0]  save_index_q, save_index_d;
  logic [7:0]  path_address_q, path_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  word_addr_q, word_addr_d;
  // Read pipeline: rd_valid_q marks a byte slot arriving this cycle,
  // term_q marks that slot as the terminator rather than a path byte,
  // term2_q marks the cycle in which the terminator's word is written.
  logic        rd_valid_q, rd_valid_d;
  logic        term_q, term_d;
  logic        term2_q, term2_d;

  logic        pk_word_valid_s;
  logic [31:0] pk_word_s;
  logic [7:0]  pk_byte_s;

  assign pk_byte_s = term_q ? 8'h00 : path_q;

  byte_word_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_valid (rd_valid_q),
    .byte_in    (pk_byte_s),
    .flush      (term_q),
    .word_valid (pk_word_valid_s),
    .word       (pk_word_s)
  );

  // Sequencer next-state and output decode
  always_comb begin
    state_d        = state_q;
    save_index_d   = save_index_q;
    path_address_d = path_address_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    rd_valid_d     = (state_q == ST_READ) || (state_q == ST_PAD);
    term_d         = (state_q == ST_PAD);
    term2_d        = term_q;
    word_addr_d    = pk_word_valid_s ? (word_addr_q + 6'd1) : word_addr_q;

    case (state_q)
      ST_IDLE: begin
        path_address_d = 8'd0;
        if (start) begin
          save_index_d = save_index_in;
          word_addr_d  = BASE_ADDR;
          busy_d       = 1'b1;
          state_d      = ST_READ;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_READ: begin
        if (path_address_q == LAST_ADDR) begin
          path_address_d = 8'd0;
          state_d        = ST_PAD;
        end else begin
          path_address_d = path_address_q + 8'd1;
        end
      end
      ST_PAD: begin
        // The terminator slot enters the read pipeline behind the last byte
        state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (term2_q) begin
          // Final word is being written now; signal done next cycle
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        busy_d         = 1'b0;
        path_address_d = 8'd0;
        state_d        = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      save_index_q   <= 7'd0;
      path_address_q <= 8'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      word_addr_q    <= BASE_ADDR;
      rd_valid_q     <= 1'b0;
      term_q         <= 1'b0;
      term2_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      save_index_q   <= save_index_d;
      path_address_q <= path_address_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      word_addr_q    <= word_addr_d;
      rd_valid_q     <= rd_valid_d;
      term_q         <= term_d;
      term2_q        <= term2_d;
    end
  end

  assign save_index   = save_index_q;
  assign path_address = path_address_q;
  assign word_wr      = pk_word_valid_s;
  assign word_addr    = word_addr_q;
  assign word_data    = pk_word_s;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: doc/save_path_packer.md
SAVE_PATH_PACKER -- requirements
Module: save_path_packer

Interface
REQ-001 SHALL have parameter PATH_LENGTH, default 32, meaning the number of path bytes read from the upstream path source (1..252).
REQ-002 SHALL have parameter BASE_WORD_ADDR, default 0, meaning the first 32-bit word address written in the bridge buffer.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to build the path for save_index_in.
REQ-006 SHALL have port save_index_in, input, 7 bits: requested save slot number (0..99).
REQ-007 SHALL have port save_index, output, 7 bits: slot number latched at start, held stable to the path source.
REQ-008 SHALL have port path_address, output, 8 bits: byte address to the path source.
REQ-009 SHALL have port path_q, input, 8 bits: path byte, valid exactly 1 cycle after path_address.
REQ-010 SHALL have port word_wr, output, 1 bit: write strobe to the bridge buffer.
REQ-011 SHALL have port word_addr, output, 6 bits: bridge buffer word address.
REQ-012 SHALL have port word_data, output, 32 bits: packed path word.
REQ-013 SHALL have port busy, output, 1 bit: high from the cycle after accepted start until done.
REQ-014 SHALL have port done, output, 1 bit: single-cycle pulse when the final word is written.

Function
REQ-015 SHALL implement states IDLE, READ, PAD, FINISH.
REQ-016 In IDLE, start SHALL latch save_index_in into save_index, clear the byte counter, and go to READ; start while busy SHALL be ignored.
REQ-017 In READ, path_address SHALL equal the byte counter, incrementing by 1 per cycle from 0 to PATH_LENGTH-1; throughput is 1 byte/cycle.
REQ-018 path_q SHALL be captured 1 cycle after its address is issued, via a 1-deep valid pipeline.
REQ-019 Bytes SHALL be packed big-endian: byte 4k+0 in [31:24], 4k+1 in [23:16], 4k+2 in [15:8], 4k+3 in [7:0].
REQ-020 word_wr SHALL pulse for 1 cycle in the cycle after the 4th byte of a word is captured, with word_addr = BASE_WORD_ADDR + k.
REQ-021 After the last path byte is captured, PAD SHALL append one 0x00 terminator, then 0x00 fill to a 4-byte boundary.
REQ-022 Total words written SHALL be ceil((PATH_LENGTH+1)/4); the default is 9 words (36 bytes).
REQ-023 word_addr SHALL wrap modulo 64 (6-bit arithmetic).
REQ-024 FINISH SHALL pulse done for 1 cycle, coinciding with the cycle after the final word_wr, then return to IDLE.
REQ-025 save_index SHALL remain unchanged from start until the next accepted start.
REQ-026 In IDLE, path_address SHALL be 0 and word_wr SHALL be 0.

Reset
REQ-027 Asserting reset_n low SHALL immediately force IDLE and drive busy=0, done=0, word_wr=0, word_addr=BASE_WORD_ADDR, word_data=0, path_address=0, save_index=0.
REQ-028 Reset mid-operation SHALL abandon the sequence with no further writes; a partial buffer is acceptable.
REQ-029 Deassertion SHALL need no extra cycles; start in the first cycle after deassertion SHALL be accepted.

Structure
REQ-030 The state enum and the default PATH_LENGTH constant SHALL live in the shared file package, alongside the path prefix/suffix lengths.
REQ-031 The byte-to-word shift/pack register SHALL be a sub-module, byte_word_packer, with inputs byte_valid/byte_in/flush and outputs word_valid/word.
REQ-032 Design SHALL be fully synchronous to clk, except for the asynchronous reset.

Verification
REQ-033 The bench SHALL model the path source ("/Saves/camera/common/SRAM_" + 2 BCD digits + ".sav") with 1-cycle latency.
REQ-034 Scenario: start with index 7 -> 9 writes at addr 0..8; w0=0x2F536176, w5=0x2F535241, w6=0x4D5F3037, w7=0x2E736176, w8=0x00000000; done one cycle after w8.
REQ-035 Scenario: start with index 99 -> w6=0x4D5F3939; the other words are unchanged from the index-7 case.
REQ-036 Scenario: a second start pulse (index 42) while busy -> ignored; save_index stays 7 and exactly 9 writes occur.
REQ-037 Scenario: PATH_LENGTH=3 -> 1 word, 0x2F536100; PATH_LENGTH=4 -> 2 words, 0x2F536176 and 0x00000000.
REQ-038 Scenario: reset_n low after the 3rd word_wr -> no further word_wr or done; a new start after release -> full 9-word sequence.
REQ-039 Scenario: BASE_WORD_ADDR=60 -> words written to addr 60..63, then 0..4 (wrap).
